ula_command_queue: RTL and testbench

Buffered command-issue stage that sits directly upstream of the 8-bit ULA datapath (adder, subtractor, AND, OR). It accepts operation commands (opcode, two operands, carry/borrow-in) through a valid/ready handshake, queues them in a DEPTH-entry FIFO, evaluates the ULA operation on the queue head, and holds the result with flags in an output register drained through a second valid/ready handshake. It decouples the command producer from the result consumer and sustains one command per cycle.

---
 rtl/ula_command_queue.sv | 142 ++++++++++++++
 tb/tb_ula_command_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_command_queue.sv
// ula_command_queue: DEPTH-entry command FIFO feeding a WIDTH-bit ULA (ADD/SUB/AND/OR) with a
// registered, handshaked result stage. Define ULA_STICKY_CARRY_EN to build the sticky carry flag.
module ula_command_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [1:0]               OP,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic                     CIN,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         RESULT,
  output logic                     COUT,
  output logic                     ZERO,
  output logic [$clog2(DEPTH):0]   COUNT,
  input  logic                     CLR_STICKY,
  output logic                     STICKY
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic             push, load;
  cmd_t             head;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;

  assign IN_READY = (count_q < (PW+1)'(DEPTH));
  assign push     = IN_VALID && IN_READY;
  assign load     = (count_q != '0) && (!out_valid_q || OUT_READY);
  assign head     = mem_q[rd_ptr_q];

  // Borrow-out is the sign bit of the (WIDTH+1)-bit difference.
  always_comb begin
    sum      = {1'b0, head.a} + {1'b0, head.b} + {{WIDTH{1'b0}}, head.cin};
    diff     = {1'b0, head.a} - {1'b0, head.b} - {{WIDTH{1'b0}}, head.cin};
    alu_res  = '0;
    alu_cout = 1'b0;
    case (head.op)
      2'b00: begin alu_res = sum[WIDTH-1:0];  alu_cout = sum[WIDTH];  end
      2'b01: begin alu_res = diff[WIDTH-1:0]; alu_cout = diff[WIDTH]; end
      2'b10: alu_res = head.a & head.b;
      default: alu_res = head.a | head.b;
    endcase
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = load ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    if (load) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      cout_d      = alu_cout;
      zero_d      = (alu_res == '0);
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
    end
  end

  // Storage needs no reset: a reset empties the queue through the pointers.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= '{op: OP, a: A, b: B, cin: CIN};
  end

  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign COUT      = cout_q;
  assign ZERO      = zero_q;
  assign COUNT     = count_q;

`ifdef ULA_STICKY_CARRY_EN
  logic sticky_q, sticky_d;

  // Set on consumption of a carrying result takes priority over clear.
  always_comb begin
    sticky_d = sticky_q;
    if (out_valid_q && OUT_READY && cout_q) sticky_d = 1'b1;
    else if (CLR_STICKY)                    sticky_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign STICKY = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = CLR_STICKY;
  assign STICKY            = 1'b0;
`endif

endmodule

// File: tb/tb_ula_command_queue.sv
// Directed bench for ula_command_queue (DEPTH=4, WIDTH=8): reset, ALU vectors, capacity,
// streaming with pointer wrap, mid-stream reset and the optional sticky flag.
module tb_ula_command_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic       CLK = 1'b0, RST = 1'b1;
  logic       IN_VALID = 1'b0, OUT_READY = 1'b0, CIN = 1'b0, CLR_STICKY = 1'b0;
  logic [1:0] OP = 2'b00;
  logic [7:0] A = 8'h00, B = 8'h00;
  logic       IN_READY, OUT_VALID, COUT, ZERO, STICKY;
  logic [7:0] RESULT;
  logic [2:0] COUNT;

  int total = 0;
  int passed = 0;

`ifdef ULA_STICKY_CARRY_EN
  localparam logic STK_EN = 1'b1;
`else
  localparam logic STK_EN = 1'b0;
`endif

  ula_command_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OP(OP), .A(A), .B(B),
    .CIN(CIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT), .COUT(COUT),
    .ZERO(ZERO), .COUNT(COUNT), .CLR_STICKY(CLR_STICKY), .STICKY(STICKY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    IN_VALID = v; OP = op; A = a; B = b; CIN = c;
  endtask

  task automatic do_reset();
    RST = 1'b1; OUT_READY = 1'b0; CLR_STICKY = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    RST = 1'b0;
  endtask

  // Reference ALU in integer arithmetic: returns {cout, result}.
  function automatic logic [8:0] ref_alu(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic c);
    int s;
    int ia = int'(a), ib = int'(b), ic = int'(c);
    case (op)
      2'b00: begin s = ia + ib + ic; return {(s > 255), 8'(s)}; end
      2'b01: begin s = ia - ib - ic; return {(ia < ib + ic), 8'(s)}; end
      2'b10: return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Directed ALU vectors with hand-computed results.
  logic [1:0] d_op [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2};
  logic [7:0] d_a  [8] = '{8'hFF, 8'h10, 8'hF0, 8'hF0, 8'h05, 8'h7F, 8'h20, 8'h0F};
  logic [7:0] d_b  [8] = '{8'h01, 8'h20, 8'h3C, 8'h0F, 8'h05, 8'h00, 8'h20, 8'hF0};
  logic       d_c  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] d_r  [8] = '{8'h00, 8'hF0, 8'h30, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00};
  logic       d_co [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       d_z  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // Capacity commands: 03, 01, 0A, 55, 01/c1, FF/c1.
  logic [1:0] c_op [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] c_a  [6] = '{8'h01, 8'h05, 8'hAA, 8'h50, 8'h80, 8'h00};
  logic [7:0] c_b  [6] = '{8'h02, 8'h03, 8'h0F, 8'h05, 8'h80, 8'h01};
  logic       c_c  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [1:0] s_op [16];
  logic [7:0] s_a [16], s_b [16];
  logic       s_c [16];
  logic [8:0] exp9;
  logic       rb;
  int         acc;

  initial begin
    // Reset state
    tick(); tick();
    RST = 1'b0;
    chk("rst_out_valid", 16'(OUT_VALID), 16'd0);
    chk("rst_count", 16'(COUNT), 16'd0);
    chk("rst_in_ready", 16'(IN_READY), 16'd1);
    chk("rst_result", 16'(RESULT), 16'h00);
    chk("rst_cout", 16'(COUT), 16'd0);
    chk("rst_zero", 16'(ZERO), 16'd0);
    chk("rst_sticky", 16'(STICKY), 16'd0);

    // Directed ALU vectors: push at edge N, result after N+1, held while not ready
    for (int i = 0; i < 8; i++) begin
      OUT_READY = 1'b1;
      drive(1'b1, d_op[i], d_a[i], d_b[i], d_c[i]);
      tick();
      drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      chk($sformatf("vec%0d_lat_valid", i), 16'(OUT_VALID), 16'd0);
      chk($sformatf("vec%0d_lat_count", i), 16'(COUNT), 16'd1);
      tick();
      chk($sformatf("vec%0d_valid", i), 16'(OUT_VALID), 16'd1);
      chk($sformatf("vec%0d_result", i), 16'(RESULT), 16'(d_r[i]));
      chk($sformatf("vec%0d_cout", i), 16'(COUT), 16'(d_co[i]));
      chk($sformatf("vec%0d_zero", i), 16'(ZERO), 16'(d_z[i]));
      OUT_READY = 1'b0;
      tick();
      chk($sformatf("vec%0d_hold", i), 16'({OUT_VALID, RESULT}), 16'({1'b1, d_r[i]}));
    end
    // Drain with an empty queue: valid falls, result/flags hold
    OUT_READY = 1'b1;
    tick();
    chk("drain_valid", 16'(OUT_VALID), 16'd0);
    chk("drain_hold", 16'({COUT, ZERO, RESULT}), 16'({1'b0, 1'b1, 8'h00}));
    OUT_READY = 1'b0;
    tick();
    chk("idle_no_load", 16'({OUT_VALID, COUNT}), 16'd0);

    // Capacity with OUT_READY low: DEPTH+1 accepted, 6th held
    do_reset();
    acc = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(1'b1, c_op[acc], c_a[acc], c_b[acc], c_c[acc]);
      rb = IN_READY;
      tick();
      if (rb) acc++;
    end
    chk("cap_accepted", 16'(acc), 16'd5);
    chk("cap_count", 16'(COUNT), 16'd4);
    chk("cap_in_ready", 16'(IN_READY), 16'd0);
    exp9 = ref_alu(c_op[0], c_a[0], c_b[0], c_c[0]);
    chk("cap_head", 16'({OUT_VALID, RESULT}), 16'({1'b1, exp9[7:0]}));
    tick();
    chk("cap_stall", 16'({IN_READY, COUNT, RESULT}), 16'({1'b0, 3'd4, exp9[7:0]}));
    OUT_READY = 1'b1;
    for (int k = 1; k < 6; k++) begin
      rb = IN_READY;
      tick();
      if (rb && IN_VALID) begin acc++; IN_VALID = 1'b0; end
      exp9 = ref_alu(c_op[k], c_a[k], c_b[k], c_c[k]);
      chk($sformatf("cap_out%0d", k), 16'({OUT_VALID, COUT, RESULT}), 16'({1'b1, exp9}));
    end
    chk("cap_all_accepted", 16'(acc), 16'd6);
    tick();
    chk("cap_empty", 16'({OUT_VALID, COUNT}), 16'd0);

    // Streaming 16 random commands, one per cycle, wrapping the pointers
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_op[i] = 2'($urandom_range(0, 3));
      s_a[i]  = 8'($urandom_range(0, 255));
      s_b[i]  = 8'($urandom_range(0, 255));
      s_c[i]  = 1'($urandom_range(0, 1));
    end
    OUT_READY = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) begin
        drive(1'b1, s_op[c], s_a[c], s_b[c], s_c[c]);
        chk($sformatf("str%0d_in_ready", c), 16'(IN_READY), 16'd1);
      end else begin
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
      end
      tick();
      if (c == 0) begin
        chk("str_first_latency", 16'(OUT_VALID), 16'd0);
      end else begin
        exp9 = ref_alu(s_op[c-1], s_a[c-1], s_b[c-1], s_c[c-1]);
        chk($sformatf("str%0d_out", c - 1), 16'({OUT_VALID, COUT, RESULT}), 16'({1'b1, exp9}));
      end
      chk($sformatf("str%0d_count", c), 16'(COUNT), (c < 16) ? 16'd1 : 16'd0);
    end
    tick();
    chk("str_end", 16'(OUT_VALID), 16'd0);

    // Reset mid-stream: 3 queued plus one held result are discarded
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 8'h11 + 8'(i), 8'h22, 1'b0);
      tick();
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    chk("mid_pre", 16'({OUT_VALID, COUNT, RESULT}), 16'({1'b1, 3'd3, 8'h33}));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_valid", 16'(OUT_VALID), 16'd0);
    chk("mid_rst_count", 16'(COUNT), 16'd0);
    chk("mid_rst_in_ready", 16'(IN_READY), 16'd1);
    chk("mid_rst_result", 16'({COUT, ZERO, RESULT}), 16'd0);
    OUT_READY = 1'b1;
    drive(1'b1, 2'b11, 8'h12, 8'h34, 1'b1);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    chk("mid_new_lat", 16'(OUT_VALID), 16'd0);
    tick();
    chk("mid_new_out", 16'({OUT_VALID, COUT, ZERO, RESULT}), 16'({1'b1, 1'b0, 1'b0, 8'h36}));
    tick();
    chk("mid_no_stale", 16'({OUT_VALID, COUNT}), 16'd0);

    // Sticky carry flag (stays 0 when not built)
    do_reset();
    drive(1'b1, 2'b00, 8'h80, 8'h80, 1'b0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    chk("stk_held_carry", 16'({OUT_VALID, COUT, RESULT}), 16'({1'b1, 1'b1, 8'h00}));
    chk("stk_not_consumed", 16'(STICKY), 16'd0);
    OUT_READY = 1'b1;
    tick();
    chk("stk_set", 16'(STICKY), 16'(STK_EN));
    OUT_READY = 1'b0;
    drive(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    chk("stk_second_carry", 16'({OUT_VALID, COUT, RESULT}), 16'({1'b1, 1'b1, 8'hFE}));
    CLR_STICKY = 1'b1;
    OUT_READY  = 1'b1;
    tick();
    chk("stk_set_wins", 16'(STICKY), 16'(STK_EN));
    OUT_READY = 1'b0;
    tick();
    CLR_STICKY = 1'b0;
    chk("stk_clear", 16'(STICKY), 16'd0);
    tick();
    chk("stk_stays_clear", 16'(STICKY), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
